// File: rtl/rom_port_arb_pkg.sv
// Shared constants and encodings for the instruction-ROM port arbiter.
// Values mirror the project-wide instruction-memory definitions.
package rom_port_arb_pkg;

    localparam int unsigned INST_MEM_NUM = 131071;

    localparam logic        CHIP_ENABLE  = 1'b1;
    localparam logic        CHIP_DISABLE = 1'b0;
    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;

    // Encoding of the requester that won the most recent grant.
    typedef enum logic {
        ROM_REQ_IF = 1'b0,
        ROM_REQ_LS = 1'b1
    } rom_req_e;

endpackage

// File: rtl/rom_port_arb_addr_chk.sv
// Combinational alignment / range check of a ROM byte address.
module rom_addr_chk
    import rom_port_arb_pkg::*;
#(
    parameter int unsigned DEPTH = INST_MEM_NUM
) (
    input  logic [31:0] i_addr,
    output logic        o_err
);

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    logic w_misaligned;
    logic w_out_of_range;

    assign w_misaligned   = |i_addr[1:0];
    assign w_out_of_range = ({2'b00, i_addr[31:2]} >= DEPTH_W);
    assign o_err          = w_misaligned | w_out_of_range;

endmodule

// File: rtl/rom_port_arb.sv
// Shares the instruction ROM read port between fetch (IF) and load (LS);
// one access per cycle, round-robin on conflict, registered responses.
module rom_port_arb
    import rom_port_arb_pkg::*;
#(
    parameter int unsigned DEPTH = INST_MEM_NUM
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_rerr,
    input  logic        flush,
    input  logic        ls_req,
    input  logic [31:0] ls_addr,
    output logic        ls_gnt,
    output logic        ls_rvalid,
    output logic [31:0] ls_rdata,
    output logic        ls_rerr,
    output logic        rom_ce,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_inst
);

    rom_req_e    r_last_gnt;
    logic        r_if_rvalid;
    logic [31:0] r_if_rdata;
    logic        r_if_rerr;
    logic        r_ls_rvalid;
    logic [31:0] r_ls_rdata;
    logic        r_ls_rerr;

    logic        w_if_elig;
    logic        w_ls_elig;
    logic        w_if_gnt;
    logic        w_ls_gnt;
    logic        w_any_gnt;
    logic [31:0] w_gnt_addr;
    logic        w_addr_err;
    logic        w_rom_ce;
    logic [31:0] w_cap_data;

    assign w_if_elig = if_req & ~flush;
    assign w_ls_elig = ls_req;

    // On conflict, the requester that did not win last time goes first.
    // Grants are forced low while reset is asserted.
    assign w_if_gnt = rst & w_if_elig & (~w_ls_elig | (r_last_gnt == ROM_REQ_LS));
    assign w_ls_gnt = rst & w_ls_elig & (~w_if_elig | (r_last_gnt == ROM_REQ_IF));
    assign w_any_gnt = w_if_gnt | w_ls_gnt;

    assign w_gnt_addr = w_ls_gnt ? ls_addr : if_addr;

    rom_addr_chk #(
        .DEPTH (DEPTH)
    ) u_addr_chk (
        .i_addr (w_gnt_addr),
        .o_err  (w_addr_err)
    );

    assign w_rom_ce   = w_any_gnt & ~w_addr_err;
    assign w_cap_data = w_addr_err ? ZERO_WORD : rom_inst;

    assign rom_ce   = w_rom_ce ? CHIP_ENABLE : CHIP_DISABLE;
    assign rom_addr = w_rom_ce ? w_gnt_addr : ZERO_WORD;

    assign if_gnt = w_if_gnt;
    assign ls_gnt = w_ls_gnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_gnt  <= ROM_REQ_LS;
            r_if_rvalid <= 1'b0;
            r_if_rdata  <= ZERO_WORD;
            r_if_rerr   <= 1'b0;
            r_ls_rvalid <= 1'b0;
            r_ls_rdata  <= ZERO_WORD;
            r_ls_rerr   <= 1'b0;
        end else begin
            r_if_rvalid <= w_if_gnt;
            r_ls_rvalid <= w_ls_gnt;
            if (w_if_gnt) begin
                r_last_gnt <= ROM_REQ_IF;
                r_if_rdata <= w_cap_data;
                r_if_rerr  <= w_addr_err;
            end
            if (w_ls_gnt) begin
                r_last_gnt <= ROM_REQ_LS;
                r_ls_rdata <= w_cap_data;
                r_ls_rerr  <= w_addr_err;
            end
        end
    end

    // A redirect discards any IF response landing in the same cycle.
    assign if_rvalid = r_if_rvalid & ~flush;
    assign if_rerr   = r_if_rerr & ~flush;
    assign if_rdata  = r_if_rdata;

    assign ls_rvalid = r_ls_rvalid;
    assign ls_rerr   = r_ls_rerr;
    assign ls_rdata  = r_ls_rdata;

endmodule

// File: tb/tb_rom_port_arb.sv
// Randomised scoreboard bench for rom_port_arb: a driver predicts grants and
// queues expected responses, a separate monitor checks them as they appear.
module tb_rom_port_arb;

    localparam int unsigned DEPTH = 131071;
    localparam logic [31:0] TOP_OK  = 32'(4 * DEPTH - 4);
    localparam logic [31:0] TOP_BAD = 32'(4 * DEPTH);

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_rerr;
    logic        flush;
    logic        ls_req;
    logic [31:0] ls_addr;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        ls_rerr;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;

    rom_port_arb #(
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .if_rerr   (if_rerr),
        .flush     (flush),
        .ls_req    (ls_req),
        .ls_addr   (ls_addr),
        .ls_gnt    (ls_gnt),
        .ls_rvalid (ls_rvalid),
        .ls_rdata  (ls_rdata),
        .ls_rerr   (ls_rerr),
        .rom_ce    (rom_ce),
        .rom_addr  (rom_addr),
        .rom_inst  (rom_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] idx);
        if (idx == 32'd2) return 32'h3401_0011;
        return (idx * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    endfunction

    // ROM contents; a disabled ROM returns a poison pattern.
    always_comb rom_inst = rom_ce ? rom_word({2'b00, rom_addr[31:2]}) : 32'hDEAD_BEEF;

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    rsp_t        if_q[$];
    rsp_t        ls_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          model_last_ls = 1;    // 1: LS won last, 0: IF won last
    logic [31:0] if_last = 32'h0;
    logic [31:0] ls_last = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    function automatic logic addr_bad(input logic [31:0] a);
        return (a % 4 != 0) || ((a / 4) >= DEPTH);
    endfunction

    task automatic drive(input logic ir, input logic [31:0] ia, input logic lr,
                         input logic [31:0] la, input logic fl);
        bit   if_el, ls_el, g_if, g_ls, bad;
        logic [31:0] ga;
        rsp_t r;
        @(negedge clk);
        cyc++;
        if_req = ir; if_addr = ia; ls_req = lr; ls_addr = la; flush = fl;
        #1;
        if_el = ir && !fl;
        ls_el = lr;
        g_if  = if_el && (!ls_el || model_last_ls == 1);
        g_ls  = ls_el && (!if_el || model_last_ls == 0);
        ga    = g_ls ? la : ia;
        bad   = addr_bad(ga);
        chk("if_gnt", 32'(if_gnt), 32'(g_if));
        chk("ls_gnt", 32'(ls_gnt), 32'(g_ls));
        chk("rom_ce", 32'(rom_ce), 32'((g_if || g_ls) && !bad));
        chk("rom_addr", rom_addr, ((g_if || g_ls) && !bad) ? ga : 32'h0);
        r.cyc  = cyc + 1;
        r.err  = bad;
        r.data = bad ? 32'h0 : rom_word(ga / 4);
        if (g_if) begin if_q.push_back(r); model_last_ls = 0; end
        if (g_ls) begin ls_q.push_back(r); model_last_ls = 1; end
    endtask

    // Reset asserted mid-cycle, between a capturing edge and the sample point.
    task automatic pulse_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
        if_req = 1'b1; ls_req = 1'b1; flush = 1'b0;
        if_addr = 32'h10; ls_addr = 32'h20;
        #1;
        chk("rst_if_rvalid", 32'(if_rvalid), 32'h0);
        chk("rst_ls_rvalid", 32'(ls_rvalid), 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_ls_rdata", ls_rdata, 32'h0);
        chk("rst_if_gnt", 32'(if_gnt), 32'h0);
        chk("rst_ls_gnt", 32'(ls_gnt), 32'h0);
        chk("rst_rom_ce", 32'(rom_ce), 32'h0);
        chk("rst_rom_addr", rom_addr, 32'h0);
        if_q.delete();
        ls_q.delete();
        model_last_ls = 1;
        if_last = 32'h0;
        ls_last = 32'h0;
        #1;
        rst = 1'b1;
        if_req = 1'b0; ls_req = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 5))
            0: return 32'($urandom_range(0, 1023)) << 2;
            1: return (32'($urandom_range(0, 4095)) << 2) | 32'($urandom_range(1, 3));
            2: return TOP_OK;
            3: return TOP_BAD;
            4: return $urandom;
            default: return 32'($urandom_range(0, DEPTH - 1)) << 2;
        endcase
    endfunction

    // Monitor: every cycle, each response port either matches the queued
    // expectation for this cycle or stays idle with its data held.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                if (if_q.size() > 0 && if_q[0].cyc == cyc) begin
                    e = if_q.pop_front();
                    chk("if_rvalid", 32'(if_rvalid), 32'(!flush));
                    chk("if_rerr", 32'(if_rerr), 32'(e.err && !flush));
                    chk("if_rdata", if_rdata, e.data);
                    if_last = e.data;
                end else begin
                    chk("if_rvalid_idle", 32'(if_rvalid), 32'h0);
                    chk("if_rdata_hold", if_rdata, if_last);
                end
                if (ls_q.size() > 0 && ls_q[0].cyc == cyc) begin
                    e = ls_q.pop_front();
                    chk("ls_rvalid", 32'(ls_rvalid), 32'h1);
                    chk("ls_rerr", 32'(ls_rerr), 32'(e.err));
                    chk("ls_rdata", ls_rdata, e.data);
                    ls_last = e.data;
                end else begin
                    chk("ls_rvalid_idle", 32'(ls_rvalid), 32'h0);
                    chk("ls_rdata_hold", ls_rdata, ls_last);
                end
            end
        end
    end

    initial begin
        rst = 1'b0;
        if_req = 1'b1; ls_req = 1'b1; flush = 1'b0;
        if_addr = 32'h8; ls_addr = 32'h8;
        #2;
        chk("por_if_gnt", 32'(if_gnt), 32'h0);
        chk("por_rom_ce", 32'(rom_ce), 32'h0);
        chk("por_if_rdata", if_rdata, 32'h0);
        chk("por_ls_rvalid", 32'(ls_rvalid), 32'h0);
        #1;
        rst = 1'b1;
        if_req = 1'b0; ls_req = 1'b0;

        drive(1'b1, 32'h8, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

        pulse_reset();
        for (int i = 0; i < 6; i++) drive(1'b1, 32'(i * 4), 1'b1, 32'(64 + i * 4), 1'b0);

        drive(1'b0, 32'h0, 1'b1, 32'h6, 1'b0);
        drive(1'b0, 32'h0, 1'b1, TOP_BAD, 1'b0);
        drive(1'b1, TOP_OK, 1'b0, 32'h0, 1'b0);
        drive(1'b1, TOP_BAD, 1'b0, 32'h0, 1'b0);

        drive(1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
        drive(1'b1, 32'h44, 1'b1, 32'h80, 1'b1);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

        drive(1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
        drive(1'b1, 32'h4, 1'b0, 32'h0, 1'b0);
        drive(1'b1, 32'h8, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

        drive(1'b0, 32'h0, 1'b1, 32'hC, 1'b0);
        drive(1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
        pulse_reset();
        drive(1'b1, 32'h4, 1'b1, 32'h8, 1'b0);
        drive(1'b1, 32'h4, 1'b1, 32'h8, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 3) != 0, rand_addr(),
                  $urandom_range(0, 2) != 0, rand_addr(),
                  $urandom_range(0, 7) == 0);
        end

        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        #3;
        if (if_q.size() != 0 || ls_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL leftover_responses actual=%0d required=0", if_q.size() + ls_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rom_port_arb.md
# rom_port_arb

Two-requester arbiter that shares the single read port of the instruction ROM between the fetch stage (IF) and a data-side load path (LS) used for PC-relative literal/constant reads. Issues at most one ROM access per cycle, registers the returned word into a one-cycle-latency response per requester, and flags misaligned or out-of-range addresses instead of reading. Sits between `pc_reg`/`mem` and the instruction ROM and drives the ROM's `ce`/`addr` inputs.

## Interface
- `DEPTH`, default 131071: ROM depth in 32-bit words, equal to `InstMemNum`.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  IF read request; held with `if_addr` until `if_gnt`.
- `if_addr`  in  32  IF byte address (`InstAddrBus`).
- `if_gnt`  out  1  IF request accepted this cycle (combinational).
- `if_rvalid`  out  1  IF response valid.
- `if_rdata`  out  32  IF instruction word (`InstBus`).
- `if_rerr`  out  1  IF response is an error (misaligned/out of range).
- `flush`  in  1  branch/exception redirect: kill IF traffic this cycle.
- `ls_req`, `ls_addr`, `ls_gnt`, `ls_rvalid`, `ls_rdata`, `ls_rerr`: same widths and meanings for the LS requester (no flush input).
- `rom_ce`  out  1  ROM chip enable (`ChipEnable`/`ChipDisable`).
- `rom_addr`  out  32  ROM byte address.
- `rom_inst`  in  32  ROM read word, combinational from `rom_ce`/`rom_addr`.

## Operation
- Eligible requesters in cycle t: LS if `ls_req`; IF if `if_req && !flush`.
- One eligible requester: it is granted. Both eligible: round-robin on `last_gnt` register — grant the one NOT granted last; `last_gnt` updates only on a grant.
- Reset value of `last_gnt` = LS, so IF wins the first conflict.
- Address check on the granted address: error if `addr[1:0] != 0` or `addr[31:2] >= DEPTH`.
- Good grant: `rom_ce = ChipEnable`, `rom_addr` = granted address; `rom_inst` is captured into that requester's `rdata` register at the edge ending cycle t, with `rerr` = 0.
- Error grant: `rom_ce = ChipDisable`, `rom_addr = ZeroWord`; the captured `rdata` is `ZeroWord` and `rerr` = 1.
- No grant: `rom_ce = ChipDisable`, `rom_addr = ZeroWord`.
- Each requester's `rvalid` register is set iff that requester was granted in the previous cycle, otherwise cleared. `rdata` holds its last value while `rvalid` = 0.
- Flush: `if_rvalid` output = `if_rvalid_q && !flush`. A response arriving during a flush cycle is discarded; `if_rerr` is gated the same way. LS is unaffected.

## Timing
- Grant: same cycle as request (combinational). Response: exactly 1 cycle after grant; no back-pressure on responses.
- Throughput: one grant per cycle total. Under continuous conflict, grants alternate IF, LS, IF, ...
- Reset (asynchronous, any cycle): `if_rvalid`/`ls_rvalid` = 0, `if_rdata`/`ls_rdata` = `ZeroWord`, `if_rerr`/`ls_rerr` = 0, `last_gnt` = LS. While `rst` = 0 the combinational outputs are forced: `if_gnt` = `ls_gnt` = 0, `rom_ce = ChipDisable`, `rom_addr = ZeroWord`. An in-flight response is lost.
- `flush` with `ls_req` in the same cycle: LS is granted without contention; `last_gnt` becomes LS.
- Request withdrawn before grant: legal, no state change.
- Address `4*DEPTH - 4`: valid. Address `4*DEPTH`: error.

## Structure
- `DEPTH` default, and the macros `InstMemNum`, `ChipEnable`, `ChipDisable` and `ZeroWord`, come from `defines.v`. Add `RomReqIF` and `RomReqLS` (encodings of `last_gnt`) there.
- One sub-module: `rom_addr_chk` (combinational range/alignment check), instantiated once on the granted address. The rest is flat: the grant mux plus per-requester response registers.

## Test plan
- IF only, `if_addr` = 0x8, ROM word 0x3401_0011 -> `if_gnt` = 1 in cycle t, `rom_ce` = 1, `rom_addr` = 0x8; `if_rvalid` = 1 with `if_rdata` = 0x3401_0011 in t+1.
- Both requesting continuously for 6 cycles from reset -> grant order IF, LS, IF, LS, IF, LS; each response one cycle after its grant.
- `ls_addr` = 0x6 (misaligned) and `ls_addr` = 4*DEPTH -> `ls_gnt` = 1, `rom_ce` = 0, next cycle `ls_rvalid` = 1, `ls_rerr` = 1, `ls_rdata` = 0.
- IF granted at t, `flush` = 1 at t+1 with `if_req` = 1 and `ls_req` = 1 -> `if_rvalid` = 0 at t+1, `if_gnt` = 0, `ls_gnt` = 1.
- `rst` pulsed low mid-cycle after a grant -> `rvalid` drops immediately; after release, the first conflict grants IF.
- Back-to-back IF at 0x0, 0x4, 0x8 -> three consecutive `if_rvalid` cycles carrying ROM words 0, 1, 2.
